// File: rtl/mole_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mole_scheduler_if
// Purpose  : Groups the game-control, random-stream, button, LED and score
//            signals of the mole scheduler into one bundle.
// Ports    : play, rnd_valid, rnd, hit   -> into the scheduler
//            mole, score, miss,
//            hit_pulse, miss_pulse       <- out of the scheduler
// Modports : master - the driving side (LFSR, buttons, game control)
//            slave  - the scheduler itself
// Revision : 1.0 - initial release
// ============================================================================
interface mole_scheduler_if #(
  parameter int N_MOLES = 9
);
  logic               play;
  logic               rnd_valid;
  logic [3:0]         rnd;
  logic [N_MOLES-1:0] hit;
  logic [N_MOLES-1:0] mole;
  logic [7:0]         score;
  logic [7:0]         miss;
  logic               hit_pulse;
  logic               miss_pulse;

  modport master (
    output play, rnd_valid, rnd, hit,
    input  mole, score, miss, hit_pulse, miss_pulse
  );

  modport slave (
    input  play, rnd_valid, rnd, hit,
    output mole, score, miss, hit_pulse, miss_pulse
  );
endinterface
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mole_scheduler
// Purpose  : Consumes the 4-bit LFSR stream, maps samples onto a mole index
//            with rejection (out of range or repeat of the previous mole),
//            lights that mole for UP_CYCLES, then keeps it dark for
//            GAP_CYCLES. Rising edges on the lit mole's button count as hits,
//            timeouts count as misses; both tallies saturate at 255.
// Ports    : clock  - system clock, rising edge
//            resetn - asynchronous active-low reset
//            bus    - mole_scheduler_if.slave (play, rnd_valid, rnd, hit in;
//                     mole, score, miss, hit_pulse, miss_pulse out)
// Revision : 1.0 - initial release
// ============================================================================
module mole_scheduler #(
  parameter int N_MOLES    = 9,
  parameter int UP_CYCLES  = 50000000,
  parameter int GAP_CYCLES = 25000000,
  parameter int MAX_RETRY  = 15
) (
  input  wire logic         clock,
  input  wire logic         resetn,
  mole_scheduler_if.slave   bus
);

  // Timer only has to reach the larger of the two phase lengths minus one.
  localparam int c_TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int c_TW   = (c_TMAX > 2) ? $clog2(c_TMAX) : 1;

  localparam logic [c_TW-1:0] c_UP_LAST  = c_TW'(UP_CYCLES - 1);
  localparam logic [c_TW-1:0] c_GAP_LAST = c_TW'(GAP_CYCLES - 1);
  localparam logic [3:0]      c_RETRY_LAST = 4'(MAX_RETRY - 1);
  localparam logic [3:0]      c_NO_LAST  = 4'hF;
  localparam logic [4:0]      c_NMOLES5  = 5'(N_MOLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PICK = 2'd1,
    S_UP   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [N_MOLES-1:0] r_mole,   w_mole_nxt;
  logic [7:0]         r_score,  w_score_nxt;
  logic [7:0]         r_miss,   w_miss_nxt;
  logic               r_hit_pulse,  w_hit_pulse_nxt;
  logic               r_miss_pulse, w_miss_pulse_nxt;
  logic [c_TW-1:0]    r_timer,  w_timer_nxt;
  logic [3:0]         r_retry,  w_retry_nxt;
  logic [3:0]         r_last,   w_last_nxt;
  logic [N_MOLES-1:0] r_hit_q;

  logic [N_MOLES-1:0] w_hit_rise;
  logic               w_hit_lit;
  logic [3:0]         w_fallback;
  logic               w_accept;
  logic [3:0]         w_cand;
  logic [N_MOLES-1:0] w_onehot;

  // The button history is refreshed every cycle regardless of state, so a
  // button held across a mole change never produces a new rising edge.
  assign w_hit_rise = bus.hit & ~r_hit_q;

  // Rising edge on the button of the mole that is currently lit.
  always_comb begin
    w_hit_lit = 1'b0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (r_last == 4'(i)) begin
        w_hit_lit = w_hit_rise[i];
      end
    end
  end

  // Forced pick: next index after the previous mole; "no previous" acts as -1.
  always_comb begin
    if (r_last == c_NO_LAST) begin
      w_fallback = 4'd0;
    end else if ({1'b0, r_last} + 5'd1 >= c_NMOLES5) begin
      w_fallback = 4'd0;
    end else begin
      w_fallback = r_last + 4'd1;
    end
  end

  assign w_onehot = {{(N_MOLES-1){1'b0}}, 1'b1} << w_cand;

  // Candidate selection in PICK: a valid in-range non-repeat sample is taken
  // directly; the MAX_RETRY-th rejection takes the fallback instead.
  always_comb begin
    w_accept = 1'b0;
    w_cand   = 4'd0;
    if (r_state == S_PICK && bus.rnd_valid) begin
      if (({1'b0, bus.rnd} < c_NMOLES5) && (bus.rnd != r_last)) begin
        w_accept = 1'b1;
        w_cand   = bus.rnd;
      end else if (r_retry == c_RETRY_LAST) begin
        w_accept = 1'b1;
        w_cand   = w_fallback;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mole_nxt       = r_mole;
    w_score_nxt      = r_score;
    w_miss_nxt       = r_miss;
    w_hit_pulse_nxt  = 1'b0;
    w_miss_pulse_nxt = 1'b0;
    w_timer_nxt      = r_timer;
    w_retry_nxt      = r_retry;
    w_last_nxt       = r_last;

    if (!bus.play) begin
      w_state_nxt = S_IDLE;
      w_mole_nxt  = '0;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_mole_nxt  = '0;
          w_score_nxt = 8'd0;
          w_miss_nxt  = 8'd0;
          w_retry_nxt = 4'd0;
          w_timer_nxt = '0;
          w_last_nxt  = c_NO_LAST;
          w_state_nxt = S_PICK;
        end

        S_PICK: begin
          w_mole_nxt = '0;
          if (w_accept) begin
            w_mole_nxt  = w_onehot;
            w_last_nxt  = w_cand;
            w_retry_nxt = 4'd0;
            w_timer_nxt = '0;
            w_state_nxt = S_UP;
          end else if (bus.rnd_valid) begin
            w_retry_nxt = r_retry + 4'd1;
          end
        end

        S_UP: begin
          // A hit takes priority over a timeout landing on the same cycle.
          if (w_hit_lit) begin
            w_score_nxt     = (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
            w_hit_pulse_nxt = 1'b1;
            w_mole_nxt      = '0;
            w_timer_nxt     = '0;
            w_state_nxt     = S_GAP;
          end else if (r_timer == c_UP_LAST) begin
            w_miss_nxt       = (r_miss == 8'hFF) ? 8'hFF : r_miss + 8'd1;
            w_miss_pulse_nxt = 1'b1;
            w_mole_nxt       = '0;
            w_timer_nxt      = '0;
            w_state_nxt      = S_GAP;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end

        S_GAP: begin
          w_mole_nxt = '0;
          if (r_timer == c_GAP_LAST) begin
            w_timer_nxt = '0;
            w_state_nxt = S_PICK;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end

        default: begin
          w_mole_nxt  = '0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_mole       <= '0;
      r_score      <= 8'd0;
      r_miss       <= 8'd0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_timer      <= '0;
      r_retry      <= 4'd0;
      r_last       <= c_NO_LAST;
      r_hit_q      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mole       <= w_mole_nxt;
      r_score      <= w_score_nxt;
      r_miss       <= w_miss_nxt;
      r_hit_pulse  <= w_hit_pulse_nxt;
      r_miss_pulse <= w_miss_pulse_nxt;
      r_timer      <= w_timer_nxt;
      r_retry      <= w_retry_nxt;
      r_last       <= w_last_nxt;
      r_hit_q      <= bus.hit;
    end
  end

  assign bus.mole       = r_mole;
  assign bus.score      = r_score;
  assign bus.miss       = r_miss;
  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.miss_pulse = r_miss_pulse;

endmodule
`default_nettype wire
